tile_fill_engine: RTL and testbench
===================================

# tile_fill_engine

Rectangle-fill controller and write-port arbiter for the 64×64 tile map. It owns the tile memory write port and shares it between two sources: direct CPU tile writes in the iomem window 0x0520_0000, and a hardware fill sequencer programmed through registers at 0x0530_0000. The fill sequencer writes one tile index per clock over a CPU-defined rectangle, so the CPU no longer has to loop over the map. It sits between the SoC iomem bus and the tile memory write side, in the `clk` domain.

## Interface
Parameters: none.

Clock/reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  system clock; also the tile memory write clock
- `reset`  in  1  synchronous, active-high
- `iomem_valid`  in  1  bus request
- `iomem_ready`  out  1  one-cycle acknowledge
- `iomem_wstrb`  in  4  byte strobes; only bit 0 is used; 0 means read
- `iomem_addr`  in  32  byte address; decode `[23:20]`: 4'h2 = tile window, 4'h3 = register window
- `iomem_wdata`  in  32  write data
- `iomem_rdata`  out  32  read data, valid while `iomem_ready`=1
- `tm_wen`  out  1  tile memory write enable
- `tm_waddr`  out  12  tile address {row[5:0], col[5:0]}
- `tm_wdata`  out  6  tile index
- `busy`  out  1  fill in progress
- `irq_done`  out  1  one-cycle pulse on fill completion

## Operation
Register window (`addr[3:2]`). Writes require `wstrb[0]`.
- 0 CTRL
  - Write: bit0=1 starts a fill; bit1=1 clears DONE.
  - Read: {30'b0, busy, DONE}.
- 1 ORIGIN: `[5:0]` x0, `[13:8]` y0.
- 2 SIZE: `[6:0]` w, `[14:8]` h. Legal range 0..64 each; a field value above 64 is treated as 64.
- 3 VALUE: `[5:0]` tile index; `[8]` INCR (see Configuration).

Register rules:
- All fields reset to 0.
- Read-back returns the written fields; unused bits read 0.
- Reads of the tile window return 0.

Bus handshake:
- A request in either window with `iomem_ready`=0 is accepted. `iomem_ready` goes to 1 on the next cycle, for exactly one cycle.
- The master holds `valid` until it sees `ready`.
- Addresses outside both windows are ignored; `ready` stays 0.

FSM: IDLE, FILL.
- IDLE→FILL: accepted CTRL write with bit0=1, w≠0 and h≠0.
  - Latch x0, y0, w, h, value and INCR.
  - Clear column counter i and row counter j.
- Start with w=0 or h=0: stay in IDLE, set DONE, pulse `irq_done`, issue no writes.
- Start while in FILL: ignored. ORIGIN/SIZE/VALUE writes while in FILL take effect only at the next start.
- FILL, each cycle without a CPU tile write (see Arbitration), emit one write:
  - address {(y0+j) mod 64, (x0+i) mod 64}
  - data = current value
  - then advance i. When i reaches w−1, set i←0 and j←j+1.
- After the write with i=w−1 and j=h−1: FILL→IDLE, set DONE, pulse `irq_done`.

Arbitration:
- A CPU tile-window write accepted in a cycle wins the port: `tm_waddr`=`iomem_addr[13:2]`, `tm_wdata`=`iomem_wdata[5:0]`.
- In that cycle the fill sequencer stalls: i, j and value hold. No address is skipped or duplicated.

Reset mid-fill: return to IDLE and abandon the fill. DONE, all registers and all outputs go to 0.

## Timing
- Reset value of every output: 0.
- `tm_*`, `busy`, `irq_done`, `iomem_ready` and `iomem_rdata` are registered.
- Start accepted in cycle T:
  - `iomem_ready` and `busy` rise at T+1.
  - The first fill write is on `tm_*` at T+2.
- With no stalls, writes run in w·h consecutive cycles. Each CPU tile write adds exactly 1 cycle.
- On the cycle the last fill write appears on `tm_*`: `busy`=0 and `irq_done`=1.
- Zero-size start: `irq_done` at T+1, `busy` never rises.
- A CPU tile write accepted in cycle C appears on `tm_*` at C+1, regardless of FSM state.

## Configuration
- `TILE_FILL_INCR_EN` defined:
  - VALUE[8]=1 makes the value increment by 1 after each emitted fill write, wrapping 63→0.
  - VALUE[8] reads back as written.
- Not defined:
  - VALUE[8] is not stored and reads 0.
  - Every fill write uses the constant latched value.

## Test plan
- Reset: all outputs are 0; reading CTRL, ORIGIN, SIZE and VALUE returns 0.
- Basic fill (x0=2, y0=3, w=3, h=2, value=5):
  - exactly 6 consecutive writes, to 0x0C2, 0x0C3, 0x0C4, 0x102, 0x103, 0x104, all with data 5;
  - `irq_done` pulses on the 6th write; CTRL reads 0x1; writing CTRL bit1 clears it to 0x0.
- Wrap (x0=62, y0=63, w=4, h=2): writes go to 0xFFE, 0xFFF, 0xFC0, 0xFC1, 0x03E, 0x03F, 0x000, 0x001.
- CPU write of 0x2A to 0x0520_0010 during the 3rd fill write:
  - `tm_*` = 0x004 / 0x2A for one cycle;
  - the fill sequence resumes with no skip or duplicate;
  - `busy` lasts one cycle longer.
- Increment (value=0x3E, INCR=1, w=4, h=1):
  - with `TILE_FILL_INCR_EN`: data 0x3E, 0x3F, 0x00, 0x01;
  - without it: 0x3E four times.
- Corner cases:
  - w=0 start: no writes, DONE set, one `irq_done` pulse.
  - Start during a fill: ignored, write count unchanged.
  - Reset asserted mid-fill: `tm_wen` is 0 from the next cycle, `busy`=0, DONE=0.

Source files
------------

// File: rtl/tile_fill_engine.sv
// Tile memory write-port owner: CPU tile writes plus a rectangle fill sequencer.
// Optional TILE_FILL_INCR_EN enables per-write value increment (VALUE[8]).
module tile_fill_engine (
  input  logic        clk,
  input  logic        reset,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic        tm_wen,
  output logic [11:0] tm_waddr,
  output logic [5:0]  tm_wdata,
  output logic        busy,
  output logic        irq_done
);

  typedef enum logic {IDLE, FILL} state_t;
  state_t state_q, state_d;

  // programmed registers
  logic [5:0] x0_r, y0_r, val_r;
  logic [6:0] w_r, h_r;
  // copies latched at start
  logic [5:0] x0_q, y0_q, val_q, i_q, j_q;
  logic [6:0] w_q, h_q;
  logic       done_q;
`ifdef TILE_FILL_INCR_EN
  logic       incr_r, incr_q;
`endif

  logic        sel_tile, sel_reg, accept, cpu_wr, reg_wr, ctrl_wr;
  logic        start_req, zero_start, fill_start, emit, fill_last;
  logic        col_last, row_last;
  logic [6:0]  w_eff, h_eff;
  logic [5:0]  fill_row, fill_col;
  logic [31:0] rd_mux;
  logic        unused_bits;

  assign unused_bits = ^{iomem_wstrb[3:1], iomem_addr[31:24], iomem_addr[19:14],
                         iomem_addr[1:0], iomem_wdata[31:15], iomem_wdata[7]};

  function automatic logic [6:0] clamp64(input logic [6:0] v);
    return (v > 7'd64) ? 7'd64 : v;
  endfunction

  assign sel_tile   = (iomem_addr[23:20] == 4'h2);
  assign sel_reg    = (iomem_addr[23:20] == 4'h3);
  assign accept     = iomem_valid && !iomem_ready && (sel_tile || sel_reg);
  assign cpu_wr     = accept && sel_tile && iomem_wstrb[0];
  assign reg_wr     = accept && sel_reg && iomem_wstrb[0];
  assign ctrl_wr    = reg_wr && (iomem_addr[3:2] == 2'd0);
  assign w_eff      = clamp64(w_r);
  assign h_eff      = clamp64(h_r);
  assign start_req  = ctrl_wr && iomem_wdata[0] && (state_q == IDLE);
  assign zero_start = start_req && ((w_eff == 7'd0) || (h_eff == 7'd0));
  assign fill_start = start_req && !zero_start;
  assign col_last   = ({1'b0, i_q} == (w_q - 7'd1));
  assign row_last   = ({1'b0, j_q} == (h_q - 7'd1));
  assign fill_row   = y0_q + j_q;
  assign fill_col   = x0_q + i_q;
  assign busy       = (state_q == FILL);

  // A CPU tile write steals the port for its cycle; the sequencer simply holds.
  always_comb begin
    state_d   = state_q;
    emit      = 1'b0;
    fill_last = 1'b0;
    case (state_q)
      IDLE: if (fill_start) state_d = FILL;
      FILL: begin
        emit      = !cpu_wr;
        fill_last = emit && col_last && row_last;
        if (fill_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_mux = '0;
    case (iomem_addr[3:2])
      2'd0: rd_mux = {30'b0, busy, done_q};
      2'd1: rd_mux = {18'b0, y0_r, 2'b0, x0_r};
      2'd2: rd_mux = {17'b0, h_r, 1'b0, w_r};
`ifdef TILE_FILL_INCR_EN
      2'd3: rd_mux = {23'b0, incr_r, 2'b0, val_r};
`else
      2'd3: rd_mux = {26'b0, val_r};
`endif
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      iomem_ready <= 1'b0;
      iomem_rdata <= '0;
      tm_wen      <= 1'b0;
      tm_waddr    <= '0;
      tm_wdata    <= '0;
      irq_done    <= 1'b0;
      done_q      <= 1'b0;
      x0_r        <= '0;
      y0_r        <= '0;
      w_r         <= '0;
      h_r         <= '0;
      val_r       <= '0;
      x0_q        <= '0;
      y0_q        <= '0;
      w_q         <= '0;
      h_q         <= '0;
      val_q       <= '0;
      i_q         <= '0;
      j_q         <= '0;
`ifdef TILE_FILL_INCR_EN
      incr_r      <= 1'b0;
      incr_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      iomem_ready <= accept;
      iomem_rdata <= (accept && sel_reg && !iomem_wstrb[0]) ? rd_mux : '0;
      irq_done    <= zero_start || fill_last;

      if (ctrl_wr && iomem_wdata[1]) done_q <= 1'b0;
      if (zero_start || fill_last) done_q <= 1'b1;

      if (reg_wr) begin
        case (iomem_addr[3:2])
          2'd1: begin
            x0_r <= iomem_wdata[5:0];
            y0_r <= iomem_wdata[13:8];
          end
          2'd2: begin
            w_r <= iomem_wdata[6:0];
            h_r <= iomem_wdata[14:8];
          end
          2'd3: begin
            val_r <= iomem_wdata[5:0];
`ifdef TILE_FILL_INCR_EN
            incr_r <= iomem_wdata[8];
`endif
          end
          default: ;
        endcase
      end

      tm_wen   <= cpu_wr || emit;
      tm_waddr <= '0;
      tm_wdata <= '0;
      if (cpu_wr) begin
        tm_waddr <= iomem_addr[13:2];
        tm_wdata <= iomem_wdata[5:0];
      end else if (emit) begin
        tm_waddr <= {fill_row, fill_col};
        tm_wdata <= val_q;
      end

      if (fill_start) begin
        x0_q  <= x0_r;
        y0_q  <= y0_r;
        w_q   <= w_eff;
        h_q   <= h_eff;
        val_q <= val_r;
        i_q   <= '0;
        j_q   <= '0;
`ifdef TILE_FILL_INCR_EN
        incr_q <= incr_r;
`endif
      end else if (emit) begin
        if (col_last) begin
          i_q <= '0;
          j_q <= j_q + 6'd1;
        end else begin
          i_q <= i_q + 6'd1;
        end
`ifdef TILE_FILL_INCR_EN
        if (incr_q) val_q <= val_q + 6'd1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_tile_fill_engine.sv
// Scoreboard bench for tile_fill_engine: a reference model builds the expected write stream.
module tb_tile_fill_engine;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        iomem_valid = 1'b0;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb = '0;
  logic [31:0] iomem_addr = '0;
  logic [31:0] iomem_wdata = '0;
  logic [31:0] iomem_rdata;
  logic        tm_wen;
  logic [11:0] tm_waddr;
  logic [5:0]  tm_wdata;
  logic        busy;
  logic        irq_done;

  localparam logic [31:0] TILE_BASE = 32'h0520_0000;
  localparam logic [31:0] REG_BASE  = 32'h0530_0000;
`ifdef TILE_FILL_INCR_EN
  localparam logic [31:0] VAL_MASK = 32'h0000_013F;
`else
  localparam logic [31:0] VAL_MASK = 32'h0000_003F;
`endif

  tile_fill_engine dut (
    .clk(clk), .reset(reset),
    .iomem_valid(iomem_valid), .iomem_ready(iomem_ready), .iomem_wstrb(iomem_wstrb),
    .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata),
    .tm_wen(tm_wen), .tm_waddr(tm_waddr), .tm_wdata(tm_wdata),
    .busy(busy), .irq_done(irq_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [11:0] a;
    logic [5:0]  d;
    int          kind;  // 0 fill, 1 last fill, 2 cpu
  } exp_t;
  exp_t q[$];

  int checks = 0, errors = 0;
  int irq_cnt = 0, exp_irq = 0, busy_cycles = 0;
  bit ignore_tm = 1'b0;
  logic [31:0] sh_origin = '0, sh_size = '0, sh_value = '0;
  bit done_exp = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  exp_t me;
  always @(negedge clk) begin
    if (irq_done) irq_cnt++;
    if (busy) busy_cycles++;
    if (tm_wen && !ignore_tm) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write", tm_waddr, tm_wdata);
      end else begin
        me = q.pop_front();
        chk("tm_waddr", {20'h0, tm_waddr}, {20'h0, me.a});
        chk("tm_wdata", {26'h0, tm_wdata}, {26'h0, me.d});
        if (me.kind != 2) begin
          chk("irq_on_write", {31'h0, irq_done}, (me.kind == 1) ? 32'd1 : 32'd0);
          chk("busy_on_write", {31'h0, busy}, (me.kind == 0) ? 32'd1 : 32'd0);
        end
      end
    end
  end

  task automatic bus_xfer(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st,
                          output logic [31:0] rd, output int acc);
    if (iomem_ready) begin @(posedge clk); #1; end
    iomem_valid = 1'b1;
    iomem_addr  = a;
    iomem_wdata = d;
    iomem_wstrb = st;
    @(posedge clk); #1;
    acc = cyc;
    for (int n = 0; n < 4 && !iomem_ready; n++) begin @(posedge clk); #1; end
    chk("bus_ready", {31'h0, iomem_ready}, 32'd1);
    rd = iomem_rdata;
    iomem_valid = 1'b0;
    iomem_wstrb = '0;
  endtask

  task automatic reg_wr(input int idx, input logic [31:0] d);
    logic [31:0] rd;
    int acc;
    bus_xfer(REG_BASE | (idx << 2), d, 4'h1, rd, acc);
    case (idx)
      0: if (d[1]) done_exp = 1'b0;
      1: sh_origin = d & 32'h0000_3F3F;
      2: sh_size   = d & 32'h0000_7F7F;
      default: sh_value = d & VAL_MASK;
    endcase
  endtask

  task automatic reg_chk(input int idx, input logic [31:0] expv, input string name);
    logic [31:0] rd;
    int acc;
    bus_xfer(REG_BASE | (idx << 2), $urandom, 4'h0, rd, acc);
    chk(name, rd, expv);
  endtask

  // d < 0: no CPU write; otherwise a CPU tile write follows the start after d idle cycles.
  task automatic do_fill(input int d, input bit restart, input logic [11:0] ca, input logic [5:0] cd);
    int x0, y0, w, h, v, n, k, t_start, c_acc, exp_busy, dd;
    bit incr;
    logic [31:0] rd;
    exp_t e;
    x0 = int'(sh_origin[5:0]);
    y0 = int'(sh_origin[13:8]);
    w  = int'(sh_size[6:0]);
    h  = int'(sh_size[14:8]);
    if (w > 64) w = 64;
    if (h > 64) h = 64;
    v    = int'(sh_value[5:0]);
    incr = sh_value[8];
    n    = w * h;
    q.delete();
    for (int j = 0; j < h; j++)
      for (int i = 0; i < w; i++) begin
        e.a    = 12'((((y0 + j) % 64) * 64) + ((x0 + i) % 64));
        e.d    = 6'(v);
        e.kind = (i == w - 1 && j == h - 1) ? 1 : 0;
        q.push_back(e);
        if (incr) v = (v + 1) % 64;
      end
    exp_busy = n;
    dd = (d < 1) ? 1 : d;
    if (d >= 0) begin
      k = dd;
      if (k < n) exp_busy++;
      else k = n;
      e.a = ca;
      e.d = cd;
      e.kind = 2;
      q.insert(k, e);
    end
    busy_cycles = 0;
    bus_xfer(REG_BASE, 32'h1, 4'h1, rd, t_start);
    chk("busy_after_start", {31'h0, busy}, (n != 0) ? 32'd1 : 32'd0);
    chk("irq_after_start", {31'h0, irq_done}, (n == 0) ? 32'd1 : 32'd0);
    if (d >= 0) begin
      repeat (d) begin @(posedge clk); #1; end
      bus_xfer(TILE_BASE | {18'h0, ca, 2'b00}, ($urandom & 32'hFFFF_FFC0) | {26'h0, cd}, 4'h1, rd, c_acc);
      chk("cpu_accept_cycle", c_acc, t_start + 1 + dd);
    end
    if (restart) begin
      reg_wr(1, $urandom);
      bus_xfer(REG_BASE, 32'h1, 4'h1, rd, c_acc);
    end
    for (int t = 0; t < 6000 && busy; t++) begin @(posedge clk); #1; end
    chk("fill_timeout", {31'h0, busy}, 32'd0);
    repeat (3) begin @(posedge clk); #1; end
    chk("queue_drained", q.size(), 0);
    exp_irq++;
    done_exp = 1'b1;
    chk("irq_count", irq_cnt, exp_irq);
    chk("busy_cycles", busy_cycles, exp_busy);
    q.delete();
  endtask

  initial begin
    #3ms;
    checks++;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    logic [31:0] rd;
    int acc, dsel, w, h;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs", {iomem_ready, iomem_rdata, tm_wen, tm_waddr, tm_wdata, busy, irq_done} == '0, 32'd1);
    reset = 1'b0;
    @(posedge clk); #1;
    reg_chk(0, 32'h0, "rst_ctrl");
    reg_chk(1, 32'h0, "rst_origin");
    reg_chk(2, 32'h0, "rst_size");
    reg_chk(3, 32'h0, "rst_value");

    // out-of-window request is never acknowledged
    iomem_valid = 1'b1;
    iomem_addr  = 32'h0540_0000;
    iomem_wstrb = 4'h1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("oow_ready", {31'h0, iomem_ready}, 32'd0);
    end
    iomem_valid = 1'b0;
    iomem_wstrb = '0;
    bus_xfer(TILE_BASE | 32'h8, 32'hFFFF_FFFF, 4'h0, rd, acc);
    chk("tile_read_zero", rd, 32'h0);

    // basic fill
    reg_wr(1, 32'h0000_0302);
    reg_wr(2, 32'h0000_0203);
    reg_wr(3, 32'h0000_0005);
    do_fill(-1, 1'b0, '0, '0);
    reg_chk(0, 32'h1, "ctrl_done");
    reg_wr(0, 32'h2);
    reg_chk(0, 32'h0, "ctrl_cleared");

    // wrap
    reg_wr(1, 32'h0000_3F3E);
    reg_wr(2, 32'h0000_0204);
    do_fill(-1, 1'b0, '0, '0);

    // CPU write during the 3rd fill write
    reg_wr(1, 32'h0000_0302);
    reg_wr(2, 32'h0000_0203);
    do_fill(2, 1'b0, 12'h004, 6'h2A);

    // increment
    reg_wr(3, 32'h0000_013E);
    reg_chk(3, 32'h13E & VAL_MASK, "value_readback");
    reg_wr(2, 32'h0000_0104);
    do_fill(-1, 1'b0, '0, '0);

    // zero-size start
    reg_wr(0, 32'h2);
    reg_wr(2, 32'h0000_0500);
    do_fill(-1, 1'b0, '0, '0);
    reg_chk(0, 32'h1, "zero_done");

    // start and ORIGIN write during a fill are ignored
    reg_wr(2, 32'h0000_0408);
    do_fill(-1, 1'b1, '0, '0);

    for (int it = 0; it < 30; it++) begin
      reg_wr(1, $urandom);
      if ($urandom_range(0, 7) == 0) begin
        w = $urandom_range(60, 127);
        h = 1;
      end else begin
        w = $urandom_range(0, 8);
        h = $urandom_range(0, 6);
      end
      reg_wr(2, ($urandom & 32'hFFFF_8080) | (h << 8) | w);
      reg_wr(3, $urandom);
      reg_chk(1, sh_origin, "origin_readback");
      reg_chk(2, sh_size, "size_readback");
      reg_chk(3, sh_value, "value_readback");
      dsel = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, 12));
      do_fill(dsel, 1'b0, 12'($urandom), 6'($urandom));
      reg_chk(0, {31'h0, done_exp}, "ctrl_after_fill");
      if ($urandom_range(0, 1) == 1) begin
        reg_wr(0, 32'h2);
        reg_chk(0, 32'h0, "ctrl_clear");
      end
    end

    // reset mid-fill
    reg_wr(1, 32'h0000_0101);
    reg_wr(2, 32'h0000_0A0A);
    ignore_tm = 1'b1;
    bus_xfer(REG_BASE, 32'h1, 4'h1, rd, acc);
    repeat (5) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst_tm_wen", {31'h0, tm_wen}, 32'd0);
    chk("midrst_busy", {31'h0, busy}, 32'd0);
    chk("midrst_irq", {31'h0, irq_done}, 32'd0);
    reset = 1'b0;
    sh_origin = '0;
    sh_size   = '0;
    sh_value  = '0;
    done_exp  = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("midrst_no_writes", {31'h0, tm_wen}, 32'd0);
    ignore_tm = 1'b0;
    q.delete();
    reg_chk(0, 32'h0, "midrst_ctrl");
    reg_chk(1, 32'h0, "midrst_origin");
    reg_chk(2, 32'h0, "midrst_size");
    chk("midrst_irq_count", irq_cnt, exp_irq);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
